vram_arbiter: RTL

Single-port video-RAM arbiter shared by the video generator's fetch port and the CPU bus. Video fetches are issued on pixel-enable slots; CPU accesses fill idle cycles. A starvation timer guarantees the CPU a slot even when video fetches occupy every cycle. The block sits between the video generator (`video_addr`/`video_data`), the CPU memory decoder and the shared RAM (fast/slow bank 1).

---
 rtl/vram_arb_pkg.sv | 22 ++
 rtl/vram_arb_starve.sv | 42 ++++
 rtl/vram_arbiter.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/vram_arb_pkg.sv
// ---------------------------------------------------------------------------
// vram_arb_pkg
// Shared types and default parameters for the video-RAM arbiter.
//   own_t            : which requester owns the access in flight (one cycle
//                      after issue)
//   DEF_AW           : default byte-address width
//   DEF_CPU_MAX_WAIT : default number of denied cycles before the CPU
//                      preempts video
// ---------------------------------------------------------------------------
package vram_arb_pkg;

   typedef enum logic [1:0] {
      NONE   = 2'd0,
      VID    = 2'd1,
      CPU_RD = 2'd2,
      CPU_WR = 2'd3
   } own_t;

   localparam int DEF_AW           = 23;
   localparam int DEF_CPU_MAX_WAIT = 8;

endpackage

// File: rtl/vram_arb_starve.sv
// ---------------------------------------------------------------------------
// vram_arb_starve
// Saturating starvation counter for the CPU side of the video-RAM arbiter.
// Counts consecutive cycles in which a CPU request is pending but not granted.
// Once the count reaches CPU_MAX_WAIT, force_cpu tells the arbiter to give
// the next slot to the CPU, even over a video fetch.
//   clk, reset : clock, asynchronous active-high reset
//   pend       : CPU request pending (not yet granted)
//   grant      : CPU granted this cycle
//   force_cpu  : CPU must be granted this cycle
// ---------------------------------------------------------------------------
module vram_arb_starve
   import vram_arb_pkg::*;
#(
   parameter int CPU_MAX_WAIT = DEF_CPU_MAX_WAIT
) (
   input  logic clk,
   input  logic reset,
   input  logic pend,
   input  logic grant,
   output logic force_cpu
);

   localparam logic [7:0] MAX_CNT = 8'(CPU_MAX_WAIT);

   logic [7:0] wait_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wait_cnt <= '0;
      end else if (!pend || grant) begin
         wait_cnt <= '0;
      end else if (wait_cnt != MAX_CNT) begin
         wait_cnt <= wait_cnt + 8'd1;
      end
   end

   // force depends only on the registered count, so there is no
   // combinational loop through the arbiter's grant logic.
   assign force_cpu = pend && (wait_cnt == MAX_CNT);

endmodule

// File: rtl/vram_arbiter.sv
// ---------------------------------------------------------------------------
// vram_arbiter
// Single-port video-RAM arbiter shared by the video fetch port and the CPU.
// Video fetches are issued on pixel-enable slots, CPU accesses fill idle
// cycles, and a starvation timer forces a CPU grant after CPU_MAX_WAIT
// denied cycles. Issue is combinational; data/ack arrive one cycle later.
//
// Ports:
//   clk, reset                     : clock, asynchronous active-high reset
//   ce_pix, vid_req, vid_addr      : video slot strobe, fetch request, address
//   vid_data, vid_valid, vid_miss  : fetched byte, update pulse, lost-slot pulse
//   cpu_req, cpu_we, cpu_addr,
//   cpu_wdata                      : CPU request (level, held until ack)
//   cpu_rdata, cpu_ack             : CPU read data, completion pulse
//   ram_ce, ram_we, ram_addr,
//   ram_wdata, ram_rdata           : shared RAM port (read data one cycle
//                                    after ram_ce)
//   miss_count, miss_clr           : only with VRAM_ARB_STATS_EN defined;
//                                    saturating vid_miss count and its clear
//
// Build option: define VRAM_ARB_STATS_EN to add the miss statistics counter.
// ---------------------------------------------------------------------------
module vram_arbiter
   import vram_arb_pkg::*;
#(
   parameter int AW           = DEF_AW,
   parameter int CPU_MAX_WAIT = DEF_CPU_MAX_WAIT
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          ce_pix,
   input  logic          vid_req,
   input  logic [AW-1:0] vid_addr,
   output logic [7:0]    vid_data,
   output logic          vid_valid,
   output logic          vid_miss,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [7:0]    cpu_wdata,
   output logic [7:0]    cpu_rdata,
   output logic          cpu_ack,
   output logic          ram_ce,
   output logic          ram_we,
   output logic [AW-1:0] ram_addr,
   output logic [7:0]    ram_wdata,
`ifdef VRAM_ARB_STATS_EN
   output logic [15:0]   miss_count,
   input  logic          miss_clr,
`endif
   input  logic [7:0]    ram_rdata
);

   own_t          own_p1, own_nxt;
   logic          cpu_busy_p1;
   logic          miss_p1;
   logic [7:0]    vid_data_p1;
   logic [7:0]    cpu_rdata_p1;
   logic [AW-1:0] addr_hold_p1;
   logic [7:0]    wdata_hold_p1;

   logic          cpu_pend;
   logic          vid_slot;
   logic          force_cpu;
   logic          grant_cpu;
   logic          grant_vid;

   assign cpu_pend = cpu_req & ~cpu_busy_p1;
   assign vid_slot = ce_pix & vid_req;

   vram_arb_starve #(
      .CPU_MAX_WAIT (CPU_MAX_WAIT)
   ) u_starve (
      .clk       (clk),
      .reset     (reset),
      .pend      (cpu_pend),
      .grant     (grant_cpu),
      .force_cpu (force_cpu)
   );

   // Issue stage: grant decision and RAM drive
   always_comb begin
      grant_cpu = 1'b0;
      grant_vid = 1'b0;
      own_nxt   = NONE;
      ram_ce    = 1'b0;
      ram_we    = 1'b0;
      ram_addr  = addr_hold_p1;
      ram_wdata = wdata_hold_p1;

      if (force_cpu) begin
         grant_cpu = 1'b1;
      end else if (vid_slot) begin
         grant_vid = 1'b1;
      end else if (cpu_pend) begin
         grant_cpu = 1'b1;
      end

      if (grant_cpu) begin
         own_nxt   = cpu_we ? CPU_WR : CPU_RD;
         ram_ce    = 1'b1;
         ram_we    = cpu_we;
         ram_addr  = cpu_addr;
         ram_wdata = cpu_wdata;
      end else if (grant_vid) begin
         own_nxt   = VID;
         ram_ce    = 1'b1;
         ram_addr  = vid_addr;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         own_p1        <= NONE;
         cpu_busy_p1   <= 1'b0;
         miss_p1       <= 1'b0;
         addr_hold_p1  <= '0;
         wdata_hold_p1 <= '0;
      end else begin
         own_p1        <= own_nxt;
         miss_p1       <= vid_slot & force_cpu;
         addr_hold_p1  <= ram_addr;
         wdata_hold_p1 <= ram_wdata;
         // Busy spans grant through ack, so a held cpu_req is not re-served
         // in the ack cycle.
         if (grant_cpu) begin
            cpu_busy_p1 <= 1'b1;
         end else if (cpu_ack) begin
            cpu_busy_p1 <= 1'b0;
         end
      end
   end

   // Completion stage: capture returned RAM data
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vid_data_p1  <= '0;
         cpu_rdata_p1 <= '0;
      end else begin
         if (own_p1 == VID) begin
            vid_data_p1 <= ram_rdata;
         end
         if (own_p1 == CPU_RD) begin
            cpu_rdata_p1 <= ram_rdata;
         end
      end
   end

   // RAM data is forwarded straight through during the completion cycle so it
   // is visible alongside vid_valid / cpu_ack; the register holds it after.
   assign vid_valid = (own_p1 == VID);
   assign cpu_ack   = (own_p1 == CPU_RD) || (own_p1 == CPU_WR);
   assign vid_miss  = miss_p1;
   assign vid_data  = (own_p1 == VID)    ? ram_rdata : vid_data_p1;
   assign cpu_rdata = (own_p1 == CPU_RD) ? ram_rdata : cpu_rdata_p1;

`ifdef VRAM_ARB_STATS_EN
   logic [15:0] miss_cnt_p1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         miss_cnt_p1 <= '0;
      end else if (miss_clr) begin
         miss_cnt_p1 <= '0;
      end else if (vid_miss && (miss_cnt_p1 != 16'hFFFF)) begin
         miss_cnt_p1 <= miss_cnt_p1 + 16'd1;
      end
   end

   assign miss_count = miss_cnt_p1;
`endif

endmodule
